// File: rtl/archel_isa_pkg.sv
// rtl/archel_isa_pkg.sv - ISA fields, opcodes, ALU/write-back codes and sequencer states
package archel_isa_pkg;

  localparam int OP_HI  = 15;
  localparam int OP_LO  = 12;
  localparam int DST_HI = 11;
  localparam int DST_LO = 9;
  localparam int SRC_HI = 8;
  localparam int SRC_LO = 6;
  localparam int IMM_HI = 5;
  localparam int IMM_LO = 0;

  localparam logic [3:0] OP_NOP  = 4'd0;
  localparam logic [3:0] OP_MOV  = 4'd1;
  localparam logic [3:0] OP_LDI  = 4'd2;
  localparam logic [3:0] OP_ADD  = 4'd3;
  localparam logic [3:0] OP_SUB  = 4'd4;
  localparam logic [3:0] OP_AND  = 4'd5;
  localparam logic [3:0] OP_OR   = 4'd6;
  localparam logic [3:0] OP_BZ   = 4'd7;
  localparam logic [3:0] OP_JMP  = 4'd8;
  localparam logic [3:0] OP_HALT = 4'd15;

  localparam logic [2:0] ALU_ADD    = 3'd0;
  localparam logic [2:0] ALU_SUB    = 3'd1;
  localparam logic [2:0] ALU_AND    = 3'd2;
  localparam logic [2:0] ALU_OR     = 3'd3;
  localparam logic [2:0] ALU_PASS_B = 3'd4;

  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_IMM = 2'd1;
  localparam logic [1:0] WB_RFB = 2'd2;

  typedef enum logic [1:0] {
    ST_FETCH  = 2'd0,
    ST_DECODE = 2'd1,
    ST_EXEC   = 2'd2,
    ST_HALT   = 2'd3
  } state_e;

endpackage

// File: rtl/instr_sequencer_if.sv
// rtl/instr_sequencer_if.sv - instruction memory fetch handshake
interface instr_sequencer_if #(
  parameter int INSTR_W = 16,
  parameter int PC_W    = 8
);
  logic               imem_req;
  logic [PC_W-1:0]    imem_addr;
  logic               imem_ack;
  logic [INSTR_W-1:0] imem_data;

  modport master (output imem_req, imem_addr, input imem_ack, imem_data);
  modport slave  (input imem_req, imem_addr, output imem_ack, imem_data);
endinterface

// File: rtl/instr_sequencer_decode.sv
// rtl/instr_sequencer_decode.sv - combinational instruction decoder (module instr_decode)
module instr_decode
  import archel_isa_pkg::*;
(
  input  logic [15:0] ir,
  output logic [2:0]  alu_op,
  output logic [1:0]  wb_sel,
  output logic        writes_rf,
  output logic        is_bz,
  output logic        is_jmp,
  output logic        is_halt,
  output logic        is_illegal,
  output logic [7:0]  imm_out
);
  logic [3:0] op;

  assign op      = ir[OP_HI:OP_LO];
  assign imm_out = {2'b00, ir[IMM_HI:IMM_LO]};

  always_comb begin
    alu_op     = ALU_ADD;
    wb_sel     = WB_ALU;
    writes_rf  = 1'b0;
    is_bz      = 1'b0;
    is_jmp     = 1'b0;
    is_halt    = 1'b0;
    is_illegal = 1'b0;
    case (op)
      OP_NOP:  ;
      OP_MOV:  begin writes_rf = 1'b1; wb_sel = WB_RFB; end
      OP_LDI:  begin writes_rf = 1'b1; wb_sel = WB_IMM; end
      OP_ADD:  begin writes_rf = 1'b1; alu_op = ALU_ADD; end
      OP_SUB:  begin writes_rf = 1'b1; alu_op = ALU_SUB; end
      OP_AND:  begin writes_rf = 1'b1; alu_op = ALU_AND; end
      OP_OR:   begin writes_rf = 1'b1; alu_op = ALU_OR; end
      OP_BZ:   begin is_bz = 1'b1; alu_op = ALU_PASS_B; end
      OP_JMP:  is_jmp = 1'b1;
      OP_HALT: is_halt = 1'b1;
      default: is_illegal = 1'b1;
    endcase
  end
endmodule

// File: rtl/instr_sequencer.sv
// rtl/instr_sequencer.sv - fetch/decode/exec control FSM owning the IR and PC
module instr_sequencer
  import archel_isa_pkg::*;
#(
  parameter int              INSTR_W  = 16,
  parameter int              PC_W     = 8,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic                      clk,
  input  logic                      rst,
  instr_sequencer_if.master         imem,
  output logic [2:0]                rf_raddr_a,
  output logic [2:0]                rf_raddr_b,
  output logic [2:0]                rf_waddr,
  output logic                      rf_we,
  output logic [1:0]                wb_sel,
  output logic [2:0]                alu_op,
  output logic [7:0]                imm_out,
  input  logic                      alu_zero,
  output logic [PC_W-1:0]           pc,
  output logic                      halted,
  output logic                      illegal
);
  state_e              state_q, state_d;
  logic [PC_W-1:0]     pc_q, pc_d;
  logic [INSTR_W-1:0]  ir_q, ir_d;
  logic                halted_q, halted_d;
  logic                illegal_q, illegal_d;
  logic                started_q, started_d;

  logic [2:0] dec_alu_op;
  logic [1:0] dec_wb_sel;
  logic       dec_writes_rf, dec_is_bz, dec_is_jmp, dec_is_halt, dec_is_illegal;
  logic [7:0] dec_imm;
  logic [5:0] imm6;
  logic       req;

  instr_decode u_decode (
    .ir         (ir_q),
    .alu_op     (dec_alu_op),
    .wb_sel     (dec_wb_sel),
    .writes_rf  (dec_writes_rf),
    .is_bz      (dec_is_bz),
    .is_jmp     (dec_is_jmp),
    .is_halt    (dec_is_halt),
    .is_illegal (dec_is_illegal),
    .imm_out    (dec_imm)
  );

  assign imm6 = ir_q[IMM_HI:IMM_LO];
  // started_q holds req low through reset and for the first edge after release
  assign req            = started_q && (state_q == ST_FETCH);
  assign imem.imem_req  = req;
  assign imem.imem_addr = pc_q;
  assign rf_raddr_a     = ir_q[DST_HI:DST_LO];
  assign rf_raddr_b     = ir_q[SRC_HI:SRC_LO];
  assign rf_waddr       = ir_q[DST_HI:DST_LO];
  assign imm_out        = dec_imm;
  assign pc             = pc_q;
  assign halted         = halted_q;
  assign illegal        = illegal_q;

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    halted_d  = halted_q;
    illegal_d = illegal_q;
    started_d = 1'b1;
    rf_we     = 1'b0;
    alu_op    = ALU_ADD;
    wb_sel    = WB_ALU;
    case (state_q)
      ST_FETCH: begin
        if (req && imem.imem_ack) begin
          ir_d    = imem.imem_data;
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: state_d = ST_EXEC;
      ST_EXEC: begin
        alu_op = dec_alu_op;
        wb_sel = dec_wb_sel;
        if (dec_is_halt || dec_is_illegal) begin
          state_d   = ST_HALT;
          halted_d  = 1'b1;
          illegal_d = dec_is_illegal;
        end else begin
          rf_we   = dec_writes_rf;
          state_d = ST_FETCH;
          if (dec_is_jmp)
            pc_d = PC_W'(imm6);
          else if (dec_is_bz && alu_zero)
            pc_d = pc_q + PC_W'(1) + {{(PC_W-6){imm6[5]}}, imm6};
          else
            pc_d = pc_q + PC_W'(1);
        end
      end
      default: state_d = ST_HALT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_FETCH;
      pc_q      <= RESET_PC;
      ir_q      <= '0;
      halted_q  <= 1'b0;
      illegal_q <= 1'b0;
      started_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      halted_q  <= halted_d;
      illegal_q <= illegal_d;
      started_q <= started_d;
    end
  end
endmodule

// File: tb/tb_instr_sequencer.sv
// tb/tb_instr_sequencer.sv - directed self-checking bench for instr_sequencer
module tb_instr_sequencer;
  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] rf_raddr_a, rf_raddr_b, rf_waddr, alu_op;
  logic       rf_we, alu_zero, halted, illegal;
  logic [1:0] wb_sel;
  logic [7:0] imm_out, pc;

  int errors = 0;
  int checks = 0;

  logic       ex_we;
  logic [2:0] ex_waddr, ex_alu_op;
  logic [1:0] ex_wb_sel;
  logic [7:0] ex_imm;

  instr_sequencer_if #(.INSTR_W(16), .PC_W(8)) imem_if ();

  instr_sequencer #(.INSTR_W(16), .PC_W(8), .RESET_PC(8'd0)) dut (
    .clk        (clk),
    .rst        (rst),
    .imem       (imem_if),
    .rf_raddr_a (rf_raddr_a),
    .rf_raddr_b (rf_raddr_b),
    .rf_waddr   (rf_waddr),
    .rf_we      (rf_we),
    .wb_sel     (wb_sel),
    .alu_op     (alu_op),
    .imm_out    (imm_out),
    .alu_zero   (alu_zero),
    .pc         (pc),
    .halted     (halted),
    .illegal    (illegal)
  );

  always #5 clk = ~clk;

  task automatic do_reset();
    rst = 1'b1;
    imem_if.imem_ack = 1'b0;
    imem_if.imem_data = 16'h0;
    alu_zero = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_req(output logic to);
    to = 1'b1;
    for (int i = 0; i < 50; i++) begin
      if (imem_if.imem_req) begin
        to = 1'b0;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic run_instr(input logic [15:0] instr, input logic zero, output int we_cnt, output logic to);
    we_cnt = 0;
    alu_zero = zero;
    wait_req(to);
    if (to) return;
    imem_if.imem_data = instr;
    imem_if.imem_ack = 1'b1;
    @(negedge clk);
    imem_if.imem_ack = 1'b0;
    imem_if.imem_data = 16'h0;
    if (rf_we) we_cnt++;
    @(negedge clk);
    ex_we = rf_we; ex_waddr = rf_waddr; ex_alu_op = alu_op; ex_wb_sel = wb_sel; ex_imm = imm_out;
    if (rf_we) we_cnt++;
    @(negedge clk);
    if (rf_we) we_cnt++;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    imem_if.imem_ack = 1'b0;
    imem_if.imem_data = 16'h0;
    alu_zero = 1'b0;
    #1;
    checks++; if (imem_if.imem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b want 0", imem_if.imem_req); end
    checks++; if (pc !== 8'd0) begin errors++; $display("FAIL reset_pc: got %0d want 0", pc); end
    checks++; if ({halted, illegal, rf_we} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b want 000", {halted, illegal, rf_we}); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++; if (imem_if.imem_req !== 1'b1 || imem_if.imem_addr !== 8'd0) begin
      errors++; $display("FAIL post_reset_fetch: got req=%b addr=%0d want req=1 addr=0", imem_if.imem_req, imem_if.imem_addr);
    end
  endtask

  task automatic test_ldi();
    int n; logic to;
    run_instr(16'h2205, 1'b0, n, to);
    checks++; if (to !== 1'b0) begin errors++; $display("FAIL ldi_timeout: got %b want 0", to); end
    checks++; if ({ex_we, ex_waddr, ex_wb_sel} !== {1'b1, 3'd1, 2'd1}) begin
      errors++; $display("FAIL ldi_exec: got we=%b waddr=%0d wb=%0d want 1/1/1", ex_we, ex_waddr, ex_wb_sel);
    end
    checks++; if (ex_imm !== 8'd5) begin errors++; $display("FAIL ldi_imm: got %0d want 5", ex_imm); end
    checks++; if (n !== 1) begin errors++; $display("FAIL ldi_we_pulses: got %0d want 1", n); end
    checks++; if (pc !== 8'd1 || imem_if.imem_req !== 1'b1 || imem_if.imem_addr !== 8'd1) begin
      errors++; $display("FAIL ldi_next_fetch: got pc=%0d req=%b addr=%0d want 1/1/1", pc, imem_if.imem_req, imem_if.imem_addr);
    end
  endtask

  task automatic test_mov_delayed();
    logic to; int bad = 0;
    wait_req(to);
    checks++; if (to !== 1'b0) begin errors++; $display("FAIL mov_timeout: got %b want 0", to); end
    imem_if.imem_data = 16'h1440;
    for (int i = 0; i < 4; i++) begin
      if (imem_if.imem_req !== 1'b1 || imem_if.imem_addr !== 8'd1 || rf_we !== 1'b0) bad++;
      imem_if.imem_ack = (i == 3);
      @(negedge clk);
    end
    imem_if.imem_ack = 1'b0;
    checks++; if (bad !== 0) begin errors++; $display("FAIL mov_req_stable: got %0d bad cycles want 0", bad); end
    checks++; if (imem_if.imem_req !== 1'b0 || rf_we !== 1'b0 || rf_raddr_a !== 3'd2 || rf_raddr_b !== 3'd1) begin
      errors++; $display("FAIL mov_decode: got req=%b we=%b ra=%0d rb=%0d want 0/0/2/1", imem_if.imem_req, rf_we, rf_raddr_a, rf_raddr_b);
    end
    @(negedge clk);
    checks++; if ({rf_we, rf_waddr, wb_sel, rf_raddr_b} !== {1'b1, 3'd2, 2'd2, 3'd1}) begin
      errors++; $display("FAIL mov_exec: got we=%b waddr=%0d wb=%0d rb=%0d want 1/2/2/1", rf_we, rf_waddr, wb_sel, rf_raddr_b);
    end
    @(negedge clk);
    checks++; if (rf_we !== 1'b0 || pc !== 8'd2) begin errors++; $display("FAIL mov_after: got we=%b pc=%0d want 0/2", rf_we, pc); end
  endtask

  task automatic test_branch();
    int n; logic to;
    run_instr(16'h8004, 1'b0, n, to);
    checks++; if (pc !== 8'd4) begin errors++; $display("FAIL jmp4: got %0d want 4", pc); end
    run_instr(16'h70FE, 1'b1, n, to);
    checks++; if (pc !== 8'd3) begin errors++; $display("FAIL bz_taken_pc: got %0d want 3", pc); end
    checks++; if (n !== 0 || ex_alu_op !== 3'd4) begin errors++; $display("FAIL bz_exec: got we_cnt=%0d alu_op=%0d want 0/4", n, ex_alu_op); end
    run_instr(16'h8004, 1'b0, n, to);
    run_instr(16'h70FE, 1'b0, n, to);
    checks++; if (pc !== 8'd5 || n !== 0) begin errors++; $display("FAIL bz_not_taken: got pc=%0d we_cnt=%0d want 5/0", pc, n); end
  endtask

  task automatic test_wrap();
    int n; logic to;
    run_instr(16'h8000, 1'b0, n, to);
    run_instr(16'h70BE, 1'b1, n, to);
    checks++; if (pc !== 8'd255) begin errors++; $display("FAIL bz_wrap_back: got %0d want 255", pc); end
    run_instr(16'h0000, 1'b0, n, to);
    checks++; if (pc !== 8'd0 || n !== 0) begin errors++; $display("FAIL nop_wrap: got pc=%0d we_cnt=%0d want 0/0", pc, n); end
    run_instr(16'h803F, 1'b0, n, to);
    checks++; if (pc !== 8'd63 || imem_if.imem_addr !== 8'd63) begin
      errors++; $display("FAIL jmp63: got pc=%0d addr=%0d want 63/63", pc, imem_if.imem_addr);
    end
  endtask

  task automatic test_halt();
    int n; int bad = 0; logic to;
    run_instr(16'hF000, 1'b0, n, to);
    checks++; if ({halted, illegal} !== 2'b10 || n !== 0) begin
      errors++; $display("FAIL halt_flags: got halted=%b illegal=%b we_cnt=%0d want 1/0/0", halted, illegal, n);
    end
    imem_if.imem_ack = 1'b1;
    for (int i = 0; i < 22; i++) begin
      if (imem_if.imem_req !== 1'b0 || pc !== 8'd63 || rf_we !== 1'b0 || halted !== 1'b1) bad++;
      @(negedge clk);
    end
    imem_if.imem_ack = 1'b0;
    checks++; if (bad !== 0) begin errors++; $display("FAIL halt_hold: got %0d bad cycles want 0", bad); end
  endtask

  task automatic test_illegal();
    int n; logic to;
    do_reset();
    run_instr(16'h9000, 1'b0, n, to);
    checks++; if ({halted, illegal} !== 2'b11 || n !== 0) begin
      errors++; $display("FAIL illegal_flags: got halted=%b illegal=%b we_cnt=%0d want 1/1/0", halted, illegal, n);
    end
    checks++; if (pc !== 8'd0 || imem_if.imem_req !== 1'b0) begin
      errors++; $display("FAIL illegal_stop: got pc=%0d req=%b want 0/0", pc, imem_if.imem_req);
    end
  endtask

  task automatic test_reset_mid_exec();
    int n; logic to;
    do_reset();
    run_instr(16'h2205, 1'b0, n, to);
    wait_req(to);
    imem_if.imem_data = 16'h3240;
    imem_if.imem_ack = 1'b1;
    @(negedge clk);
    imem_if.imem_ack = 1'b0;
    @(negedge clk);
    checks++; if ({rf_we, rf_waddr, alu_op, wb_sel, pc} !== {1'b1, 3'd1, 3'd0, 2'd0, 8'd1}) begin
      errors++; $display("FAIL add_exec: got we=%b waddr=%0d op=%0d wb=%0d pc=%0d want 1/1/0/0/1", rf_we, rf_waddr, alu_op, wb_sel, pc);
    end
    #1 rst = 1'b1;
    #1;
    checks++; if ({rf_we, imem_if.imem_req, halted} !== 3'b000 || pc !== 8'd0) begin
      errors++; $display("FAIL async_reset: got we=%b req=%b halted=%b pc=%0d want 0/0/0/0", rf_we, imem_if.imem_req, halted, pc);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++; if (imem_if.imem_req !== 1'b1 || imem_if.imem_addr !== 8'd0) begin
      errors++; $display("FAIL refetch: got req=%b addr=%0d want 1/0", imem_if.imem_req, imem_if.imem_addr);
    end
  endtask

  initial begin
    rst = 1'b1;
    imem_if.imem_ack = 1'b0;
    imem_if.imem_data = 16'h0;
    alu_zero = 1'b0;
    test_reset();
    test_ldi();
    test_mov_delayed();
    test_branch();
    test_wrap();
    test_halt();
    test_illegal();
    test_reset_mid_exec();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
